// File: rtl/instr_fetch_seq_if.sv
// Fetch-sequencer bus bundle: PC hand-off, memory read port and decode handshake.
interface instr_fetch_seq_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic                  fetch_req;
    logic                  flush;
    logic [31:0]           pc_in;
    logic                  pc_increment;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] ir_out;
    logic                  ir_valid;
    logic                  ir_ack;
    logic                  busy;
    logic                  fault;

    // Environment side: PC register, memory and decode stage.
    modport master (
        output fetch_req, flush, pc_in, mem_ready, mem_data, ir_ack,
        input  pc_increment, mem_addr, mem_read, ir_out, ir_valid, busy, fault
    );

    // Sequencer side.
    modport slave (
        input  fetch_req, flush, pc_in, mem_ready, mem_data, ir_ack,
        output pc_increment, mem_addr, mem_read, ir_out, ir_valid, busy, fault
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: latches the PC into the MAR, pulses the PC
// increment, reads memory with a ready handshake and holds the fetched word
// in the IR until decode acknowledges it. Sticky fault on memory timeout.
module instr_fetch_seq #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                clr,
    instr_fetch_seq_if.slave    bus
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_HOLD,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  fault_q, fault_d;

    // PC bits above the memory word space are deliberately dropped.
    logic                  pc_hi_unused;
    assign pc_hi_unused = ^bus.pc_in[31:ADDR_WIDTH];

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Next-state, datapath updates and Moore-decoded outputs.
    always_comb begin
        state_d          = state_q;
        mar_d            = mar_q;
        ir_d             = ir_q;
        cnt_d            = cnt_q;
        fault_d          = fault_q;
        bus.pc_increment = 1'b0;
        bus.mem_read     = 1'b0;
        bus.ir_valid     = 1'b0;
        bus.busy         = (state_q != S_IDLE);
        bus.mem_addr     = mar_q;
        bus.ir_out       = ir_q;
        bus.fault        = fault_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.fetch_req) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                bus.pc_increment = !bus.flush;
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    // PC increments on this same edge, so MAR takes the old PC.
                    mar_d   = bus.pc_in[ADDR_WIDTH-1:0];
                    cnt_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                bus.mem_read = 1'b1;
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (bus.mem_ready) begin
                    ir_d    = bus.mem_data;
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                bus.ir_valid = 1'b1;
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (bus.ir_ack) begin
                    state_d = bus.fetch_req ? S_ADDR : S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq with a scoreboard: expected read
// addresses and fetched words are queued by the stimulus and checked by an
// independent monitor when the DUT starts a read or raises ir_valid.
module tb_instr_fetch_seq;

    localparam int AW = 9;
    localparam int DW = 32;

    logic clk;
    logic clr;

    instr_fetch_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    instr_fetch_seq #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];

    int pcinc_cnt = 0;
    int rd_cnt    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    logic          rd_prev  = 1'b0;
    logic          vld_prev = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    always @(negedge clk) begin
        if (bus.mem_read && !rd_prev) begin
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_read", 64'(bus.mem_addr), 64'h1_0000_0000);
            end else begin
                cur_addr = exp_addr_q.pop_front();
                chk("read_addr", 64'(bus.mem_addr), 64'(cur_addr));
            end
        end else if (bus.mem_read) begin
            chk("addr_stable", 64'(bus.mem_addr), 64'(cur_addr));
        end
        if (bus.ir_valid && !vld_prev) begin
            if (exp_data_q.size() == 0) begin
                chk("unexpected_ir_valid", 64'(bus.ir_out), 64'h1_0000_0000);
            end else begin
                chk("ir_out", 64'(bus.ir_out), 64'(exp_data_q.pop_front()));
            end
        end
        if (bus.mem_read)     rd_cnt++;
        if (bus.pc_increment) pcinc_cnt++;
        rd_prev  = bus.mem_read;
        vld_prev = bus.ir_valid;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int snap_pc;
    int snap_rd;

    initial begin
        clr           = 1'b1;
        bus.fetch_req = 1'b0;
        bus.flush     = 1'b0;
        bus.pc_in     = '0;
        bus.mem_ready = 1'b0;
        bus.mem_data  = '0;
        bus.ir_ack    = 1'b0;
        #3;
        chk("reset_busy",  64'(bus.busy), 64'd0);
        chk("reset_ir",    64'(bus.ir_out), 64'd0);
        chk("reset_fault", 64'(bus.fault), 64'd0);
        chk("reset_addr",  64'(bus.mem_addr), 64'd0);
        step();
        clr = 1'b0;
        step();

        // Basic fetch: pc=4, data ready in the first READ cycle.
        bus.pc_in = 32'h4; bus.mem_data = 32'hDEADBEEF; bus.mem_ready = 1'b1;
        bus.fetch_req = 1'b1;
        exp_addr_q.push_back(9'h004); exp_data_q.push_back(32'hDEADBEEF);
        snap_pc = pcinc_cnt;
        step();
        bus.fetch_req = 1'b0;
        chk("b_pcinc_addr", 64'(bus.pc_increment), 64'd1);
        chk("b_busy", 64'(bus.busy), 64'd1);
        step();
        chk("b_pcinc_read", 64'(bus.pc_increment), 64'd0);
        chk("b_mem_read", 64'(bus.mem_read), 64'd1);
        step();
        chk("b_latency_valid", 64'(bus.ir_valid), 64'd1);
        chk("b_pcinc_once", 64'(pcinc_cnt - snap_pc), 64'd1);
        bus.ir_ack = 1'b1; bus.mem_ready = 1'b0;
        step();
        bus.ir_ack = 1'b0;
        chk("b_idle_busy", 64'(bus.busy), 64'd0);
        chk("b_ir_retained", 64'(bus.ir_out), 64'hDEADBEEF);

        // Wait states: ready in the sixth READ cycle.
        bus.pc_in = 32'h10; bus.mem_data = 32'h12345678; bus.fetch_req = 1'b1;
        exp_addr_q.push_back(9'h010); exp_data_q.push_back(32'h12345678);
        step();
        bus.fetch_req = 1'b0;
        snap_rd = rd_cnt;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("w_mem_read", 64'(bus.mem_read), 64'd1);
            chk("w_no_valid", 64'(bus.ir_valid), 64'd0);
            step();
        end
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        chk("w_read_cycles", 64'(rd_cnt - snap_rd), 64'd6);
        chk("w_valid", 64'(bus.ir_valid), 64'd1);
        chk("w_fault", 64'(bus.fault), 64'd0);
        bus.ir_ack = 1'b1;
        step();
        bus.ir_ack = 1'b0;

        // Timeout: mem_ready never asserted.
        bus.pc_in = 32'h20; bus.fetch_req = 1'b1;
        exp_addr_q.push_back(9'h020);
        step();
        bus.fetch_req = 1'b0;
        snap_rd = rd_cnt;
        step();
        for (int i = 0; i < 40 && !bus.fault; i++) step();
        chk("t_read_cycles", 64'(rd_cnt - snap_rd), 64'd15);
        chk("t_fault", 64'(bus.fault), 64'd1);
        chk("t_busy", 64'(bus.busy), 64'd1);
        bus.fetch_req = 1'b1; bus.ir_ack = 1'b1;
        snap_pc = pcinc_cnt;
        repeat (3) step();
        chk("t_fault_sticky", 64'(bus.fault), 64'd1);
        chk("t_mem_read_low", 64'(bus.mem_read), 64'd0);
        chk("t_req_ignored", 64'(pcinc_cnt - snap_pc), 64'd0);
        bus.fetch_req = 1'b0; bus.ir_ack = 1'b0;
        #2 clr = 1'b1;
        #1;
        chk("t_clr_fault", 64'(bus.fault), 64'd0);
        chk("t_clr_busy", 64'(bus.busy), 64'd0);
        chk("t_clr_ir", 64'(bus.ir_out), 64'd0);
        chk("t_clr_addr", 64'(bus.mem_addr), 64'd0);
        step();
        clr = 1'b0;
        step();

        // Back-to-back: ack with fetch_req in HOLD goes straight to ADDR.
        bus.pc_in = 32'h5; bus.mem_data = 32'hA5A50001; bus.mem_ready = 1'b1;
        bus.fetch_req = 1'b1;
        exp_addr_q.push_back(9'h005); exp_data_q.push_back(32'hA5A50001);
        step();
        bus.fetch_req = 1'b0;
        step();
        step();
        chk("bb_hold", 64'(bus.ir_valid), 64'd1);
        bus.ir_ack = 1'b1; bus.fetch_req = 1'b1;
        bus.pc_in = 32'h6; bus.mem_data = 32'hA5A50002;
        exp_addr_q.push_back(9'h006); exp_data_q.push_back(32'hA5A50002);
        step();
        bus.ir_ack = 1'b0; bus.fetch_req = 1'b0;
        chk("bb_direct_addr", 64'(bus.pc_increment), 64'd1);
        chk("bb_busy", 64'(bus.busy), 64'd1);
        step();
        chk("bb_addr2", 64'(bus.mem_addr), 64'h006);
        step();
        chk("bb_valid2", 64'(bus.ir_valid), 64'd1);
        bus.ir_ack = 1'b1; bus.mem_ready = 1'b0;
        step();
        bus.ir_ack = 1'b0;

        // Flush in ADDR suppresses the increment and returns to IDLE.
        bus.pc_in = 32'h30; bus.fetch_req = 1'b1;
        step();
        bus.fetch_req = 1'b0; bus.flush = 1'b1;
        snap_pc = pcinc_cnt;
        #1;
        chk("f_pcinc_suppressed", 64'(bus.pc_increment), 64'd0);
        step();
        bus.flush = 1'b0;
        chk("f_idle", 64'(bus.busy), 64'd0);
        chk("f_no_pcinc", 64'(pcinc_cnt - snap_pc), 64'd0);
        chk("f_mar_kept", 64'(bus.mem_addr), 64'h006);

        // Flush in READ beats a coincident mem_ready.
        bus.pc_in = 32'h40; bus.mem_data = 32'hBAD0BAD0; bus.mem_ready = 1'b1;
        bus.fetch_req = 1'b1;
        exp_addr_q.push_back(9'h040);
        step();
        bus.fetch_req = 1'b0;
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0; bus.mem_ready = 1'b0;
        chk("fr_idle", 64'(bus.busy), 64'd0);
        chk("fr_ir_kept", 64'(bus.ir_out), 64'hA5A50002);
        repeat (2) step();
        chk("fr_no_valid", 64'(bus.ir_valid), 64'd0);

        // Reset mid-read, with an address above the 512-word space.
        bus.pc_in = 32'h3FF; bus.fetch_req = 1'b1;
        exp_addr_q.push_back(9'h1FF);
        step();
        bus.fetch_req = 1'b0;
        step();
        chk("r_wrap_addr", 64'(bus.mem_addr), 64'h1FF);
        snap_pc = pcinc_cnt;
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("r_mem_read", 64'(bus.mem_read), 64'd0);
        chk("r_busy", 64'(bus.busy), 64'd0);
        chk("r_ir", 64'(bus.ir_out), 64'd0);
        step();
        chk("r_no_pcinc", 64'(pcinc_cnt - snap_pc), 64'd0);
        clr = 1'b0;
        repeat (2) step();

        chk("sb_addr_drained", 64'(exp_addr_q.size()), 64'd0);
        chk("sb_data_drained", 64'(exp_data_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Fetch sequencer that sits directly downstream of the program counter register.
- Consumes the PC value, latches it into an internal MAR, and pulses the PC register's increment input.
- Issues a memory read with a ready handshake, captures the returned word into an instruction register, and presents it to decode with a valid/ack handshake.
- Provides a memory-timeout fault and a synchronous flush for branches.

Parameters:
- ADDR_WIDTH, 9, memory word-address width; MAR is the low ADDR_WIDTH bits of pc_in.
- DATA_WIDTH, 32, instruction/memory data width.
- MEM_TIMEOUT, 15, maximum READ-state cycles without mem_ready before fault; must be ≥ 1.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- clr  in  1  asynchronous active-high reset.
- fetch_req  in  1  request a fetch; sampled in IDLE and HOLD.
- flush  in  1  synchronous abort of the in-flight fetch.
- pc_in  in  32  current PC value from the PC register output.
- pc_increment  out  1  one-cycle pulse to the PC register's increment input.
- mem_addr  out  ADDR_WIDTH  MAR contents to memory.
- mem_read  out  1  memory read strobe.
- mem_ready  in  1  memory data-valid for the current read.
- mem_data  in  DATA_WIDTH  memory read data.
- ir_out  out  DATA_WIDTH  instruction register contents.
- ir_valid  out  1  ir_out holds a new instruction not yet acknowledged.
- ir_ack  in  1  decode has consumed ir_out.
- busy  out  1  high in any state other than IDLE.
- fault  out  1  sticky memory-timeout flag.

Behaviour:
- Reset:
  - Asynchronous active-high clr forces state=IDLE, MAR=0, IR=0, wait counter=0, fault=0, regardless of clk.
  - All outputs are 0 while clr is held.
- States: IDLE, ADDR, READ, HOLD, ERR. Outputs are Moore-decoded from state, except pc_increment, which is also gated by flush.
- IDLE:
  - All strobes low.
  - fetch_req=1 at posedge -> ADDR.
- ADDR (exactly one cycle):
  - pc_increment = !flush.
  - At the next posedge, MAR <= pc_in[ADDR_WIDTH-1:0], counter <= 0, state -> READ.
  - The PC register increments on that same edge, so MAR captures the pre-increment PC.
- READ:
  - mem_read=1; mem_addr=MAR (mem_addr is driven from MAR in every state).
  - mem_ready=1 at posedge: IR <= mem_data, state -> HOLD.
  - Otherwise counter increments; if the counter has reached MEM_TIMEOUT-1 at that edge -> ERR. This gives exactly MEM_TIMEOUT READ cycles before fault.
  - mem_ready takes priority over timeout in the same cycle.
- HOLD:
  - ir_valid=1; IR is stable.
  - ir_ack=1 with fetch_req=1 -> ADDR (back-to-back fetch).
  - ir_ack=1 with fetch_req=0 -> IDLE.
  - ir_ack=0 -> stay in HOLD.
- ERR:
  - fault=1, mem_read=0, ir_valid=0.
  - Remains in ERR until clr; fetch_req, flush and ir_ack are ignored.
- flush=1 in ADDR, READ or HOLD:
  - Next state is IDLE; IR is not updated; ir_valid falls next cycle.
  - flush beats mem_ready, timeout, ir_ack and fetch_req.
  - In ADDR it also suppresses pc_increment that cycle.
  - flush in IDLE has no effect.
- IR retains its last value in IDLE and after flush; ir_out always equals IR.
- Latency: fetch_req sampled at edge E0 with mem_ready high on the first READ cycle -> ir_valid high in the cycle after edge E2 (3 cycles). Each memory wait cycle adds 1.
- Asynchronous clr during READ or HOLD aborts immediately with no pc_increment or IR write.
- Address width: pc_in bits above ADDR_WIDTH-1 are ignored, so an address above 511 wraps within the 512-word space.

Test Plan:
- Basic fetch:
  - Stimulus: pc_in=0x00000004, mem_ready high in first READ cycle with mem_data=0xDEADBEEF, fetch_req one cycle.
  - Required: pc_increment high exactly 1 cycle; mem_addr=0x004; ir_out=0xDEADBEEF with ir_valid 3 cycles after request; ack -> IDLE, busy=0.
- Wait states:
  - Stimulus: mem_ready delayed 5 cycles.
  - Required: mem_read held high 6 cycles, mem_addr stable, ir_valid only after ready, fault=0.
- Timeout:
  - Stimulus: mem_ready never asserted.
  - Required: mem_read high exactly 15 cycles, then fault=1 and busy=1 held; fetch_req ignored; clr returns all outputs to 0.
- Back-to-back:
  - Stimulus: ir_ack and fetch_req both high in HOLD, pc_in=0x5, then 0x6.
  - Required: direct HOLD->ADDR with no IDLE cycle; second fetch reads address 0x006.
- Flush:
  - Stimulus: flush in ADDR.
  - Required: pc_increment=0 that cycle, IDLE next.
  - Stimulus: flush in READ coincident with mem_ready.
  - Required: IR unchanged, ir_valid never rises.
- Reset mid-read:
  - Stimulus: clr asserted between clock edges during READ.
  - Required: mem_read, busy and ir_out go 0 before the next posedge; pc_in=0x1FF+0x200 (0x3FF) fetches mem_addr=0x1FF.
